// File: rtl/ysyx_23060020_mem_pkg.sv
// Shared definitions for the data-memory controller: size codes, FSM states,
// the pmem word interface and the lane extract/merge helpers.
package ysyx_23060020_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  logic [31:0] pmem_model [logic [31:0]];

  function automatic int pmem_read(input int raddr);
    logic [31:0] key;
    key = raddr;
    if (pmem_model.exists(key)) return pmem_model[key];
    return 0;
  endfunction

  function automatic void pmem_write(input int waddr, input int wdata);
    logic [31:0] key;
    key = waddr;
    pmem_model[key] = wdata;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      SZ_B:    mask = 32'h0000_00FF;
      SZ_H:    mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << {off, 3'b000};
    data = wdata << {off, 3'b000};
    return (word & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/ysyx_23060020_mem_align.sv
// Combinational lane logic: misalignment flag, extended load value and
// merged store word for one 32-bit memory word.
module ysyx_23060020_mem_align (
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        uns,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] ldata,
  output logic [31:0] sword
);
  import ysyx_23060020_mem_pkg::*;

  assign misalign = is_misaligned(size, offset);
  assign ldata    = lane_extract(rword, size, offset, uns);
  assign sword    = lane_merge(rword, wdata, size, offset);

endmodule

// File: rtl/ysyx_23060020_mem_ctrl.sv
// Handshaked data-memory controller: one request in flight, fixed access
// latency, sized/extended loads and read-modify-write stores over pmem.
module ysyx_23060020_mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);
  import ysyx_23060020_mem_pkg::*;

  state_e      state;
  logic [3:0]  cnt;
  logic        l_wen;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [1:0]  l_size;
  logic        l_uns;
  logic        err_q;
  logic [31:0] rword_q;

  logic        accept;
  logic        access_now;
  logic        acc_wen;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [1:0]  acc_size;
  logic [31:0] wa;
  logic        misalign;
  logic [31:0] ldata;
  logic [31:0] sword_unused;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With LATENCY == 1 the access happens on the accept edge, so the live
  // request fields drive the access path while idle; afterwards the latched copy does.
  always_comb begin
    if (state == IDLE) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr[31:0];
      acc_wdata = req_wdata;
      acc_size  = req_size;
    end else begin
      acc_wen   = l_wen;
      acc_addr  = l_addr;
      acc_wdata = l_wdata;
      acc_size  = l_size;
    end
  end

  assign wa         = {acc_addr[31:2], 2'b00};
  assign access_now = (state == IDLE && accept && LATENCY == 1) ||
                      (state == WAIT && cnt == 4'd0);

  ysyx_23060020_mem_align u_align (
    .size     (acc_size),
    .offset   (acc_addr[1:0]),
    .uns      (l_uns),
    .rword    (rword_q),
    .wdata    (acc_wdata),
    .misalign (misalign),
    .ldata    (ldata),
    .sword    (sword_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      l_wen   <= 1'b0;
      l_addr  <= 32'd0;
      l_wdata <= 32'd0;
      l_size  <= 2'd0;
      l_uns   <= 1'b0;
      err_q   <= 1'b0;
      rword_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            l_wen   <= req_wen;
            l_addr  <= req_addr[31:0];
            l_wdata <= req_wdata;
            l_size  <= req_size;
            l_uns   <= req_unsigned;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              cnt   <= 4'(LATENCY - 2);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // The single memory access of a request; stores are read-modify-write.
      if (access_now) begin
        err_q   <= misalign;
        rword_q <= 32'd0;
        if (!misalign) begin
          if (acc_wen) pmem_write(wa, lane_merge(pmem_read(wa), acc_wdata, acc_size, acc_addr[1:0]));
          else         rword_q <= pmem_read(wa);
        end
      end
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = (state == RESP && !l_wen && !err_q) ? ldata : '0;

endmodule

// File: tb/tb_ysyx_23060020_mem_ctrl.sv
// Directed bench for the data-memory controller: one instance with LATENCY 1
// and one with LATENCY 4 sharing the request bus, selected by sel.
module tb_ysyx_23060020_mem_ctrl;
  import ysyx_23060020_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_ready;

  logic        req_ready0, req_ready1, resp_valid0, resp_valid1, resp_err0, resp_err1;
  logic [31:0] resp_rdata0, resp_rdata1;
  logic        m_req_ready, m_resp_valid, m_resp_err;
  logic [31:0] m_resp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_23060020_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid && !sel),
    .req_ready    (req_ready0),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid0),
    .resp_ready   (resp_ready && !sel),
    .resp_rdata   (resp_rdata0),
    .resp_err     (resp_err0)
  );

  ysyx_23060020_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .LATENCY(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid && sel),
    .req_ready    (req_ready1),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid1),
    .resp_ready   (resp_ready && sel),
    .resp_rdata   (resp_rdata1),
    .resp_err     (resp_err1)
  );

  assign m_req_ready  = sel ? req_ready1  : req_ready0;
  assign m_resp_valid = sel ? resp_valid1 : resp_valid0;
  assign m_resp_err   = sel ? resp_err1   : resp_err0;
  assign m_resp_rdata = sel ? resp_rdata1 : resp_rdata0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns,
                      output logic [31:0] rdata, output logic err, output int n);
    int guard;
    req_wen      = wen;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    req_valid    = 1'b1;
    guard        = 0;
    while (!m_req_ready && guard < 20) begin
      step();
      guard++;
    end
    step();
    req_valid = 1'b0;
    n = 1;
    while (!m_resp_valid && n < 40) begin
      step();
      n++;
    end
    rdata = m_resp_rdata;
    err   = m_resp_err;
    step();
  endtask

  task automatic run(input string tag, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rdata;
    logic        err;
    int          n;
    xfer(wen, addr, wdata, size, uns, rdata, err, n);
    check_eq({tag, ".rdata"}, rdata, exp_rdata);
    check_eq({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
    check_eq({tag, ".lat"}, n, sel ? 32'd4 : 32'd1);
  endtask

  initial begin
    logic [31:0] hold_rdata;
    logic        hold_err;
    int          n;
    int          seen;

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = SZ_W; req_unsigned = 1'b0; resp_ready = 1'b1;
    pmem_write(32'h8000_0000, 32'h0000_0000);
    pmem_write(32'h8000_0010, 32'h1122_3344);

    step();
    step();
    check_eq("rst.req_ready", {31'd0, req_ready0}, 32'd0);
    check_eq("rst.resp_valid", {31'd0, resp_valid0}, 32'd0);
    check_eq("rst.resp_rdata", resp_rdata0, 32'd0);
    check_eq("rst.resp_err", {31'd0, resp_err0}, 32'd0);
    rst = 1'b0;
    step();
    check_eq("rel.req_ready1", {31'd0, req_ready0}, 32'd1);
    check_eq("rel.req_ready4", {31'd0, req_ready1}, 32'd1);

    // LATENCY 1: sized loads/stores around 0x80000000
    run("st_w",    1'b1, 32'h8000_0000, 32'hDEAD_BEEF, SZ_W, 1'b0, 32'h0, 1'b0);
    check_eq("mem_w", pmem_read(32'h8000_0000), 32'hDEAD_BEEF);
    run("ld_bu1",  1'b0, 32'h8000_0001, 32'h0, SZ_B, 1'b1, 32'h0000_00BE, 1'b0);
    run("ld_b1",   1'b0, 32'h8000_0001, 32'h0, SZ_B, 1'b0, 32'hFFFF_FFBE, 1'b0);
    run("st_h2",   1'b1, 32'h8000_0002, 32'hAAAA_1234, SZ_H, 1'b0, 32'h0, 1'b0);
    check_eq("mem_h", pmem_read(32'h8000_0000), 32'h1234_BEEF);
    run("ld_w0",   1'b0, 32'h8000_0000, 32'h0, SZ_W, 1'b1, 32'h1234_BEEF, 1'b0);
    run("ld_h0",   1'b0, 32'h8000_0000, 32'h0, SZ_H, 1'b0, 32'hFFFF_BEEF, 1'b0);
    run("ld_hu2",  1'b0, 32'h8000_0002, 32'h0, SZ_H, 1'b1, 32'h0000_1234, 1'b0);
    run("ld_bu3",  1'b0, 32'h8000_0003, 32'h0, SZ_B, 1'b1, 32'h0000_0012, 1'b0);

    // misaligned and illegal size
    run("ld_w2",   1'b0, 32'h8000_0002, 32'h0, SZ_W, 1'b0, 32'h0, 1'b1);
    run("st_h1",   1'b1, 32'h8000_0001, 32'hFFFF_FFFF, SZ_H, 1'b0, 32'h0, 1'b1);
    check_eq("mem_mis", pmem_read(32'h8000_0000), 32'h1234_BEEF);
    run("sz3",     1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1);

    // LATENCY 4: timing, req_ready low and ignored req_valid pulses during WAIT
    sel = 1'b1;
    req_wen = 1'b0; req_addr = 32'h8000_0000; req_size = SZ_W; req_unsigned = 1'b0;
    req_valid = 1'b1;
    step();
    req_wen = 1'b1; req_wdata = 32'h0; req_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check_eq($sformatf("l4.rdy%0d", i), {31'd0, m_req_ready}, 32'd0);
      check_eq($sformatf("l4.vld%0d", i), {31'd0, m_resp_valid}, 32'd0);
      req_valid = (i < 3);
      step();
    end
    req_valid = 1'b0;
    check_eq("l4.vld4", {31'd0, m_resp_valid}, 32'd1);
    check_eq("l4.rdata", m_resp_rdata, 32'h1234_BEEF);
    check_eq("l4.rdy4", {31'd0, m_req_ready}, 32'd0);
    step();
    check_eq("l4.idle", {31'd0, m_req_ready}, 32'd1);
    check_eq("l4.mem", pmem_read(32'h8000_0000), 32'h1234_BEEF);

    // backpressure: response held for 3 cycles, handshake on the 4th
    resp_ready = 1'b0;
    req_wen = 1'b0; req_addr = 32'h8000_0000; req_size = SZ_B; req_unsigned = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    n = 1;
    while (!m_resp_valid && n < 40) begin
      step();
      n++;
    end
    check_eq("bp.lat", n, 32'd4);
    hold_rdata = m_resp_rdata;
    hold_err   = m_resp_err;
    check_eq("bp.rdata", hold_rdata, 32'hFFFF_FFEF);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_eq($sformatf("bp.vld%0d", i), {31'd0, m_resp_valid}, 32'd1);
      check_eq($sformatf("bp.data%0d", i), m_resp_rdata, 32'hFFFF_FFEF);
      check_eq($sformatf("bp.err%0d", i), {31'd0, m_resp_err}, {31'd0, hold_err});
    end
    resp_ready = 1'b1;
    step();
    check_eq("bp.rdy", {31'd0, m_req_ready}, 32'd1);
    check_eq("bp.vld_off", {31'd0, m_resp_valid}, 32'd0);

    // reset during WAIT drops a pending byte store
    req_wen = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'h0000_0055; req_size = SZ_B;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check_eq("mr.rdy_rst", {31'd0, m_req_ready}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check_eq("mr.rdy_rel", {31'd0, m_req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_resp_valid) seen++;
      step();
    end
    check_eq("mr.no_resp", seen, 32'd0);
    check_eq("mr.mem", pmem_read(32'h8000_0010), 32'h1122_3344);
    run("mr.ld", 1'b0, 32'h8000_0010, 32'h0, SZ_B, 1'b1, 32'h0000_0044, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
